// File: rtl/pipe_mux_n.sv
// N-input registered multiplexer with valid/ready handshake and a 2-entry skid buffer.
// Each output word is tagged with the effective channel index that produced it.
module pipe_mux_n #(
    parameter int W     = 5,
    parameter int N     = 2,
    parameter int SEL_W = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [N*W-1:0]   In,
    input  logic [SEL_W-1:0] S,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_sel,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clr_err,
    output logic             sel_err
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [SEL_W:0]   N_EXT = (SEL_W+1)'(N);
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(N - 1);

    state_t           state, state_next;
    logic [W-1:0]     main_data, skid_data, sel_data;
    logic [SEL_W-1:0] main_sel, skid_sel, eff_sel;
    logic             in_range, in_fire, out_fire;
    logic             load_main, load_skid, main_from_skid;

    // Out-of-range selects fall through to the last channel.
    always_comb begin
        in_range = ({1'b0, S} < N_EXT);
        eff_sel  = in_range ? S : LAST;
        sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (eff_sel == SEL_W'(k)) begin
                sel_data = In[k*W +: W];
            end
        end
    end

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_next     = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    load_main  = 1'b1;
                    state_next = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main = 1'b1;
                end else if (in_fire) begin
                    load_skid  = 1'b1;
                    state_next = TWO;
                end else if (out_fire) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    main_from_skid = 1'b1;
                    state_next     = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // A set of sel_err in the same cycle as a clear takes priority.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= EMPTY;
            main_data <= '0;
            main_sel  <= '0;
            skid_data <= '0;
            skid_sel  <= '0;
            sel_err   <= 1'b0;
        end else begin
            state <= state_next;
            if (load_main) begin
                main_data <= sel_data;
                main_sel  <= eff_sel;
            end else if (main_from_skid) begin
                main_data <= skid_data;
                main_sel  <= skid_sel;
            end
            if (load_skid) begin
                skid_data <= sel_data;
                skid_sel  <= eff_sel;
            end
            if (in_fire && !in_range) begin
                sel_err <= 1'b1;
            end else if (clr_err) begin
                sel_err <= 1'b0;
            end
        end
    end

    assign out_data = main_data;
    assign out_sel  = main_sel;

endmodule

// File: doc/pipe_mux_n.md
Name: pipe_mux_n

Overview:
- Parametrised N-input, W-bit registered multiplexer with a valid/ready handshake and a 2-entry output skid buffer.
- Next generation of the 2:1 register-field muxes in the LEGv8 datapath. It is intended for the pipelined core, at the register-address and write-back select points, where the select and data are captured at a stage boundary.
- Each output word carries the channel index that produced it.

Parameters:
- W, 5, data width of each input channel and of the output.
- N, 2, number of input channels; legal range 2..16.
- SEL_W, 1, select width; requires 2^SEL_W >= N.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  synchronous, active-high reset.
- In  input  N*W  flattened channels; channel k occupies bits [k*W+W-1 : k*W].
- S  input  SEL_W  channel select, sampled only on an input transfer.
- in_valid  input  1  upstream presents In/S.
- in_ready  output  1  block can accept a transfer this cycle.
- out_data  output  W  selected word, head of buffer.
- out_sel  output  SEL_W  effective channel index that produced out_data.
- out_valid  output  1  out_data/out_sel valid.
- out_ready  input  1  downstream accepts the head word.
- clr_err  input  1  clears sel_err.
- sel_err  output  1  sticky flag: an out-of-range select was accepted.

Behaviour:
- Transfers:
  - Input transfer (in_fire) = in_valid & in_ready.
  - Output transfer (out_fire) = out_valid & out_ready.
- Select rule:
  - S < N selects channel S.
  - S >= N selects channel N-1, the default arm; effective index = N-1.
  - The selection is evaluated combinationally from In/S and written to storage only on in_fire.
- Storage: main register (head) and skid register, each holding {data W, sel SEL_W}.
- State machine (registered, 2 bits):
  - EMPTY: out_valid=0, in_ready=1. in_fire -> main<=sel word, go to ONE.
  - ONE: out_valid=1, in_ready=1.
    - in_fire & out_fire -> main<=new word, stay ONE.
    - in_fire only -> skid<=new word, go to TWO.
    - out_fire only -> go to EMPTY.
    - Neither -> hold.
  - TWO: out_valid=1, in_ready=0 (in_valid ignored).
    - out_fire -> main<=skid, go to ONE.
    - Otherwise hold.
- in_ready and out_valid are decoded from the state register only. There is no combinational path from out_ready or in_valid to in_ready.
- Latency: a word accepted in cycle t appears on out_data in cycle t+1 if the buffer was EMPTY, or was ONE with simultaneous out_fire.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Ordering: strict FIFO; words are never dropped or duplicated.
- While out_valid=1 and out_ready=0, out_data and out_sel hold stable.
- sel_err:
  - Set on the cycle after an in_fire with S >= N.
  - Cleared on the cycle after clr_err=1.
  - If set and clear occur in the same cycle, set wins.
- RESET (any state, including mid-transfer):
  - Next edge: state=EMPTY, out_valid=0, in_ready=1, out_data=0, out_sel=0, sel_err=0; skid cleared to 0.
  - An in_fire coinciding with RESET is discarded.
- Data width rule: out_data is an exact copy of the selected W bits; no extension or truncation.

Test Plan:
- Defaults (W=5, N=2): RESET high 2 cycles, then In={5'd17,5'd9}, S=0, in_valid=1, out_ready=1 -> next cycle out_data=9, out_sel=0, out_valid=1. Then S=1 -> out_data=17, out_sel=1 one cycle later.
- N=5, SEL_W=3:
  - S=3 with channel 3=5'h1A -> out_data=1A, out_sel=3, sel_err=0.
  - S=6 with channel 4=5'h05 -> out_data=05, out_sel=4, sel_err=1 the following cycle.
  - clr_err pulse -> sel_err=0 next cycle.
- Backpressure: out_ready=0, push words A=3, B=7 -> in_ready falls to 0 after B, and out_data holds 3. Raise out_ready -> out_data 3 then 7 on consecutive cycles, and in_ready returns to 1 after the first drain.
- Full throughput: 8 consecutive pushes of 0..7 with out_ready=1 -> outputs 0..7 on cycles t+1..t+8, state never reaches TWO.
- Simultaneous push/pop in ONE: head=4, push 12 with out_ready=1 -> next cycle out_data=12, state ONE, no word lost.
- RESET in TWO with pending in_valid -> next cycle out_valid=0, in_ready=1, out_data=0, sel_err=0; the pending word never appears on the output.
